video_rot_arbiter: RTL and testbench

VIDEO_ROT_ARBITER -- requirements
Module: video_rot_arbiter

---
 rtl/video_rot_arbiter.sv | 133 +++++++++++++
 tb/tb_video_rot_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_rot_arbiter.sv
// Read-priority arbiter muxing scandoubler write (16-word) and read (8-word) bursts onto one memory port.
// Optional macro VIDEO_ROT_ARB_FAIRNESS_EN: forces a WR grant after two back-to-back RD grants that starved a pending write.
module video_rot_arbiter #(
  parameter int                    ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 22'h100000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  vidin_req,
  input  logic                  vidin_frame,
  input  logic [9:0]            vidin_row,
  input  logic [9:0]            vidin_col,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic                  vidout_frame,
  input  logic [9:0]            vidout_row,
  input  logic [9:0]            vidout_col,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_e;

  state_e      state_q;
  logic [3:0]  beat_q;
  logic        mem_req_q, mem_we_q, vidout_ack_q;
  logic [15:0] vidout_d_q;
  logic        frame_q;
  logic [9:0]  row_q, col_q;
  logic [9:0]  col_sum;
  logic        ack_ok;
  logic        grant_rd;

  // Acks that arrive with no request outstanding are stray and must not advance a burst.
  assign ack_ok = mem_ack & mem_req_q;

`ifdef VIDEO_ROT_ARB_FAIRNESS_EN
  logic [1:0] rd_cnt_q;

  assign grant_rd = vidout_req & ~(vidin_req & (rd_cnt_q == 2'd2));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= 2'd0;
    end else if (state_q == IDLE) begin
      if (grant_rd) begin
        if (!vidin_req)              rd_cnt_q <= 2'd0;
        else if (rd_cnt_q != 2'd2)   rd_cnt_q <= rd_cnt_q + 2'd1;
      end else if (vidin_req) begin
        rd_cnt_q <= 2'd0;
      end
    end
  end
`else
  assign grant_rd = vidout_req;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      vidout_ack_q <= 1'b0;
      vidout_d_q   <= 16'd0;
      frame_q      <= 1'b0;
      row_q        <= 10'd0;
      col_q        <= 10'd0;
    end else begin
      vidout_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_rd) begin
            state_q   <= RD;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            beat_q    <= 4'd0;
            frame_q   <= vidout_frame;
            row_q     <= vidout_row;
            col_q     <= vidout_col;
          end else if (vidin_req) begin
            state_q   <= WR;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            beat_q    <= 4'd0;
            frame_q   <= vidin_frame;
            row_q     <= vidin_row;
            col_q     <= vidin_col;
          end
        end
        WR: begin
          if (ack_ok) begin
            beat_q <= beat_q + 4'd1;
            if (beat_q == 4'd15) begin
              state_q   <= GAP;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
            end
          end
        end
        RD: begin
          if (ack_ok) begin
            vidout_d_q   <= mem_rdata;
            vidout_ack_q <= 1'b1;
            beat_q       <= beat_q + 4'd1;
            if (beat_q == 4'd7) begin
              state_q   <= GAP;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;  // GAP: one dead cycle so a lingering request is not re-granted
      endcase
    end
  end

  assign col_sum    = col_q + {6'd0, beat_q};
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_req_q ? BASE_ADDR + ADDR_WIDTH'({frame_q, row_q, col_sum}) : '0;
  assign mem_wdata  = (state_q == WR) ? vidin_d : 16'd0;
  assign vidin_ack  = (state_q == WR) & ack_ok;
  assign vidout_d   = vidout_d_q;
  assign vidout_ack = vidout_ack_q;

endmodule

// File: tb/tb_video_rot_arbiter.sv
// Directed bench for video_rot_arbiter: memory responder acks every second cycle and checks each beat.
module tb_video_rot_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        vidin_req = 1'b0, vidin_frame = 1'b0;
  logic [9:0]  vidin_row = '0, vidin_col = '0;
  logic [15:0] vidin_d = 16'h1234;
  logic        vidin_ack;
  logic        vidout_req = 1'b0, vidout_frame = 1'b0;
  logic [9:0]  vidout_row = '0, vidout_col = '0;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int errs = 0;
  int checks = 0;

  localparam logic [21:0] BASE = 22'h100000;

  video_rot_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [21:0] exp_addr(input logic fr, input logic [9:0] row,
                                           input logic [9:0] col, input int b);
    logic [9:0] c;
    c = col + 10'(b);
    return BASE + {1'b0, fr, row, c};
  endfunction

  // Serves one burst of nb beats; with full=1 also checks the GAP cycle after it.
  task automatic serve(input string tag, input logic we, input logic fr, input logic [9:0] row,
                       input logic [9:0] col, input int nb, input bit full);
    int beat = 0;
    int cyc = 0;
    bit pend = 0;
    bit wacked = 0;
    logic [21:0] ea;
    logic [15:0] exp_rd = '0;
    while (beat < nb && cyc < 200) begin
      @(negedge clk_sys); cyc++;
      mem_ack = 1'b0;
      if (wacked) begin vidin_d = vidin_d + 16'h0101; wacked = 0; end
      checks++;
      if (pend) begin
        if (vidout_ack !== 1'b1 || vidout_d !== exp_rd) begin
          errs++; $display("FAIL %s rd_return beat%0d: ack=%b d=%h want ack=1 d=%h", tag, beat, vidout_ack, vidout_d, exp_rd);
        end
        pend = 0;
      end else if (vidout_ack !== 1'b0) begin
        errs++; $display("FAIL %s vidout_ack_spurious: got %b want 0", tag, vidout_ack);
      end
      if (mem_req === 1'b1 && cyc % 2 == 0) begin
        ea = exp_addr(fr, row, col, beat);
        checks += 2;
        if (mem_we !== we) begin errs++; $display("FAIL %s we beat%0d: got %b want %b", tag, beat, mem_we, we); end
        if (mem_addr !== ea) begin errs++; $display("FAIL %s addr beat%0d: got %h want %h", tag, beat, mem_addr, ea); end
        exp_rd = ea[15:0] ^ 16'h5A5A;
        mem_rdata = exp_rd;
        mem_ack = 1'b1;
        #1;
        if (we) begin
          checks += 2;
          if (vidin_ack !== 1'b1) begin errs++; $display("FAIL %s vidin_ack beat%0d: got %b want 1", tag, beat, vidin_ack); end
          if (mem_wdata !== vidin_d) begin errs++; $display("FAIL %s wdata beat%0d: got %h want %h", tag, beat, mem_wdata, vidin_d); end
          wacked = 1;
        end else begin
          checks++;
          if (vidin_ack !== 1'b0) begin errs++; $display("FAIL %s vidin_ack_in_rd: got %b want 0", tag, vidin_ack); end
          pend = 1;
        end
        beat++;
      end else begin
        #1;
        checks++;
        if (vidin_ack !== 1'b0) begin errs++; $display("FAIL %s vidin_ack_no_memack: got %b want 0", tag, vidin_ack); end
      end
    end
    checks++;
    if (beat < nb) begin errs++; $display("FAIL %s timeout: beats=%0d want %0d", tag, beat, nb); end
    if (full) begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (wacked) vidin_d = vidin_d + 16'h0101;
      if (pend) begin
        checks++;
        if (vidout_ack !== 1'b1 || vidout_d !== exp_rd) begin
          errs++; $display("FAIL %s rd_return last: ack=%b d=%h want ack=1 d=%h", tag, vidout_ack, vidout_d, exp_rd);
        end
      end
      checks++;
      if (mem_req !== 1'b0) begin errs++; $display("FAIL %s gap_req: got %b want 0", tag, mem_req); end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({mem_req, mem_we, vidin_ack, vidout_ack} !== 4'b0 || mem_addr !== 22'd0 ||
        mem_wdata !== 16'd0 || vidout_d !== 16'd0) begin
      errs++; $display("FAIL reset_outputs: req=%b we=%b ia=%b oa=%b addr=%h wd=%h rd=%h want all 0",
                       mem_req, mem_we, vidin_ack, vidout_ack, mem_addr, mem_wdata, vidout_d);
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    // Stray ack with no request outstanding must do nothing.
    @(negedge clk_sys); mem_ack = 1'b1; #1;
    checks++;
    if (vidin_ack !== 1'b0) begin errs++; $display("FAIL stray_ack vidin_ack: got %b want 0", vidin_ack); end
    @(negedge clk_sys); mem_ack = 1'b0;
    checks++;
    if (vidout_ack !== 1'b0 || mem_req !== 1'b0) begin
      errs++; $display("FAIL stray_ack state: oa=%b req=%b want 0 0", vidout_ack, mem_req);
    end
  endtask

  task automatic test_write;
    @(negedge clk_sys);
    vidin_frame = 1'b1; vidin_row = 10'd5; vidin_col = 10'd32; vidin_req = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 22'h201420) begin
      errs++; $display("FAIL wr_first: req=%b we=%b addr=%h want 1 1 201420", mem_req, mem_we, mem_addr);
    end
    vidin_row = 10'd9; vidin_col = 10'd0;
    serve("wr", 1'b1, 1'b1, 10'd5, 10'd32, 16, 1);
    vidin_req = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      checks++;
      if (mem_req !== 1'b0) begin errs++; $display("FAIL wr_idle_after: got %b want 0", mem_req); end
    end
  endtask

  task automatic test_read_wrap;
    @(negedge clk_sys);
    vidout_frame = 1'b0; vidout_row = 10'd0; vidout_col = 10'd1020; vidout_req = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 22'h1003FC) begin
      errs++; $display("FAIL rd_first: req=%b we=%b addr=%h want 1 0 1003fc", mem_req, mem_we, mem_addr);
    end
    serve("rd_wrap", 1'b0, 1'b0, 10'd0, 10'd1020, 8, 1);
    vidout_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_both;
    @(negedge clk_sys);
    vidin_frame = 1'b0; vidin_row = 10'd2; vidin_col = 10'd64;
    vidout_frame = 1'b1; vidout_row = 10'd3; vidout_col = 10'd16;
    vidin_req = 1'b1; vidout_req = 1'b1;
    serve("both_rd", 1'b0, 1'b1, 10'd3, 10'd16, 8, 1);
    vidout_req = 1'b0;
    serve("both_wr", 1'b1, 1'b0, 10'd2, 10'd64, 16, 1);
    vidin_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_fairness;
    bit rd_seq [6];
`ifdef VIDEO_ROT_ARB_FAIRNESS_EN
    rd_seq = '{1, 1, 0, 1, 1, 0};
`else
    rd_seq = '{1, 1, 1, 1, 1, 1};
`endif
    @(negedge clk_sys);
    vidin_frame = 1'b1; vidin_row = 10'd8; vidin_col = 10'd200;
    vidout_frame = 1'b0; vidout_row = 10'd7; vidout_col = 10'd100;
    vidin_req = 1'b1; vidout_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rd_seq[i]) serve("fair_rd", 1'b0, 1'b0, 10'd7, 10'd100, 8, 1);
      else           serve("fair_wr", 1'b1, 1'b1, 10'd8, 10'd200, 16, 1);
    end
    vidin_req = 1'b0; vidout_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_reset_mid;
    @(negedge clk_sys);
    vidin_frame = 1'b0; vidin_row = 10'd3; vidin_col = 10'd0; vidin_req = 1'b1;
    serve("rst_part", 1'b1, 1'b0, 10'd3, 10'd0, 3, 0);
    @(negedge clk_sys);
    mem_ack = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 22'd0 || vidin_ack !== 1'b0) begin
      errs++; $display("FAIL rst_mid_async: req=%b we=%b addr=%h ia=%b want 0 0 0 0", mem_req, mem_we, mem_addr, vidin_ack);
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    serve("rst_new", 1'b1, 1'b0, 10'd3, 10'd0, 16, 1);
    vidin_req = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_hold;
    @(negedge clk_sys);
    vidin_frame = 1'b1; vidin_row = 10'd1023; vidin_col = 10'd1010; vidin_req = 1'b1;
    serve("hold", 1'b1, 1'b1, 10'd1023, 10'd1010, 16, 1);
    @(negedge clk_sys);
    vidin_req = 1'b0;
    repeat (4) begin
      @(negedge clk_sys);
      checks++;
      if (mem_req !== 1'b0) begin errs++; $display("FAIL hold_regrant: got %b want 0", mem_req); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_both();
    test_fairness();
    test_reset_mid();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
